// File: rtl/layer_input_sequencer_if.sv
// Pixel-source handshake bundle between the layer input sequencer and its environment:
// the frame request, the feature-map buffer read port and the outgoing pixel stream.
interface layer_input_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              hold;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [31:0]       row;
  logic [31:0]       col;
  logic              busy;
  logic              done;

  modport master (
    output start, hold, rd_data,
    input  rd_en, rd_addr, valid_out, data_out, row, col, busy, done
  );

  modport slave (
    input  start, hold, rd_data,
    output rd_en, rd_addr, valid_out, data_out, row, col, busy, done
  );
endinterface

// File: rtl/layer_input_sequencer.sv
// Raster-order frame source for one conv layer: reads a WIDTH x WIDTH map from a
// synchronous-read buffer, inserting GAP idle cycles between rows for border injection.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; counters cleared on accept
// S_ROW   | issuing one buffer read per cycle unless held
// S_GAP   | inter-row idle, GAP cycles, frozen by hold
// S_FLUSH | final read returning, valid_out high for the last pixel
// S_DONE  | done pulse; start ignored
module layer_input_sequencer #(
  parameter int WIDTH  = 5,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int GAP    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  layer_input_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_GAP, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_rd_row;
  logic [CW-1:0]     r_rd_col;
  logic [GW-1:0]     r_gap_cnt;
  logic [CW-1:0]     r_row_out;
  logic [CW-1:0]     r_col_out;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic w_issue;
  logic w_last_col;
  logic w_last_row;

  // hold must suppress the read in the very cycle it is asserted, so the enable is gated here
  assign w_issue    = (r_state == S_ROW) && !bus.hold;
  assign w_last_col = (r_rd_col == LAST_IDX);
  assign w_last_row = (r_rd_row == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rd_row  <= '0;
      r_rd_col  <= '0;
      r_gap_cnt <= '0;
      r_row_out <= '0;
      r_col_out <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_valid <= w_issue;
      r_done  <= 1'b0;
      if (w_issue) begin
        r_row_out <= r_rd_row;
        r_col_out <= r_rd_col;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_ROW;
            r_addr   <= '0;
            r_rd_row <= '0;
            r_rd_col <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_ROW: begin
          if (!bus.hold) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_last_col) begin
              r_rd_col <= '0;
              r_rd_row <= r_rd_row + CW'(1);
              if (w_last_row) begin
                r_state <= S_FLUSH;
              end else if (GAP > 0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= GAP_LAST;
              end
            end else begin
              r_rd_col <= r_rd_col + CW'(1);
            end
          end
        end
        S_GAP: begin
          if (!bus.hold) begin
            if (r_gap_cnt == '0) r_state <= S_ROW;
            else r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = r_addr;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = bus.rd_data;
  assign bus.row       = 32'(r_row_out);
  assign bus.col       = 32'(r_col_out);
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_layer_input_sequencer.sv
// Directed bench for layer_input_sequencer: a 5x5/GAP2 instance and a 3x3/GAP0 instance
// driven by the same start/hold/reset stimulus, each fed by a buffer model holding data = address.
module tb_layer_input_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_input_sequencer_if #(.DATA_W(16), .ADDR_W(10)) bus_a ();
  layer_input_sequencer_if #(.DATA_W(16), .ADDR_W(10)) bus_b ();

  layer_input_sequencer #(.WIDTH(5), .DATA_W(16), .ADDR_W(10), .GAP(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a)
  );
  layer_input_sequencer #(.WIDTH(3), .DATA_W(16), .ADDR_W(10), .GAP(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b)
  );

  // synchronous-read buffers, contents equal to the address
  always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= 16'(bus_a.rd_addr);
  always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= 16'(bus_b.rd_addr);

  int n_checks = 0;
  int n_errors = 0;

  int log_rd[0:127], log_addr[0:127], log_v[0:127], log_d[0:127];
  int log_row[0:127], log_col[0:127], log_busy[0:127], log_done[0:127];
  int logb_rd[0:127], logb_addr[0:127], logb_v[0:127], logb_d[0:127], logb_done[0:127];

  typedef struct {
    int cyc; int rd; int addr; int v; int d; int row; int col; int busy; int done;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus_a.start = 1'b0; bus_a.hold = 1'b0;
    bus_b.start = 1'b0; bus_b.hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Cycle 0 of every run is the cycle whose closing edge samples the first start.
  task automatic run(input int ncyc, input int hold_lo, input int hold_hi,
                     input int extra_start, input int rst_cyc, input bit start_held);
    for (int c = 0; c < ncyc; c++) begin
      bus_a.start = (c == 0) || (c == extra_start) || start_held;
      bus_a.hold  = (c >= hold_lo) && (c <= hold_hi);
      bus_b.start = bus_a.start;
      bus_b.hold  = bus_a.hold;
      rst         = !(c == rst_cyc);
      #2;
      log_rd[c]   = int'(bus_a.rd_en);   log_addr[c] = int'(bus_a.rd_addr);
      log_v[c]    = int'(bus_a.valid_out); log_d[c]  = int'(bus_a.data_out);
      log_row[c]  = int'(bus_a.row);     log_col[c]  = int'(bus_a.col);
      log_busy[c] = int'(bus_a.busy);    log_done[c] = int'(bus_a.done);
      logb_rd[c]  = int'(bus_b.rd_en);   logb_addr[c] = int'(bus_b.rd_addr);
      logb_v[c]   = int'(bus_b.valid_out); logb_d[c] = int'(bus_b.data_out);
      logb_done[c] = int'(bus_b.done);
      @(posedge clk);
      #1;
    end
    bus_a.start = 1'b0; bus_a.hold = 1'b0;
    bus_b.start = 1'b0; bus_b.hold = 1'b0;
    rst = 1'b1;
  endtask

  // Pixel k of the 5x5 frame is read at 1 + 7*row + col, shifted by sh from pixel sh_k on.
  task automatic check_frame(input string tag, input int ncyc, input int sh_k, input int sh);
    int rdq[$];
    int vq[$];
    int bad_rd, bad_v, ndone, done_at, exp_c;
    bad_rd = 0; bad_v = 0; ndone = 0; done_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (log_rd[c] != 0) rdq.push_back(c);
      if (log_v[c] != 0) vq.push_back(c);
      if (log_done[c] != 0) begin ndone++; done_at = c; end
    end
    chk({tag, "_rd_count"}, rdq.size(), 25);
    chk({tag, "_valid_count"}, vq.size(), 25);
    for (int k = 0; k < 25; k++) begin
      exp_c = 1 + (k / 5) * 7 + (k % 5) + ((k >= sh_k) ? sh : 0);
      if (k < rdq.size())
        if (rdq[k] != exp_c || log_addr[rdq[k]] != k) bad_rd++;
      if (k < vq.size())
        if (vq[k] != exp_c + 1 || log_d[vq[k]] != k ||
            log_row[vq[k]] != k / 5 || log_col[vq[k]] != k % 5) bad_v++;
    end
    chk({tag, "_rd_sequence_errs"}, bad_rd, 0);
    chk({tag, "_pixel_sequence_errs"}, bad_v, 0);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_done_cycle"}, done_at, 35 + sh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int bad, nv, nd, nr, done_at;

    tbl[0]  = '{0,  0, 0,  0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1,  1, 0,  0, 0,  0, 0, 1, 0};
    tbl[2]  = '{2,  1, 1,  1, 0,  0, 0, 1, 0};
    tbl[3]  = '{5,  1, 4,  1, 3,  0, 3, 1, 0};
    tbl[4]  = '{6,  0, 0,  1, 4,  0, 4, 1, 0};
    tbl[5]  = '{7,  0, 0,  0, 0,  0, 4, 1, 0};
    tbl[6]  = '{8,  1, 5,  0, 0,  0, 4, 1, 0};
    tbl[7]  = '{9,  1, 6,  1, 5,  1, 0, 1, 0};
    tbl[8]  = '{26, 1, 19, 1, 18, 3, 3, 1, 0};
    tbl[9]  = '{29, 1, 20, 0, 0,  3, 4, 1, 0};
    tbl[10] = '{33, 1, 24, 1, 23, 4, 3, 1, 0};
    tbl[11] = '{34, 0, 0,  1, 24, 4, 4, 1, 0};
    tbl[12] = '{35, 0, 0,  0, 0,  4, 4, 1, 1};
    tbl[13] = '{36, 0, 0,  0, 0,  4, 4, 0, 0};

    do_reset();
    chk("reset_rd_en", bus_a.rd_en, 0);
    chk("reset_rd_addr", bus_a.rd_addr, 0);
    chk("reset_valid", bus_a.valid_out, 0);
    chk("reset_row", bus_a.row, 0);
    chk("reset_col", bus_a.col, 0);
    chk("reset_busy", bus_a.busy, 0);
    chk("reset_done", bus_a.done, 0);

    // nominal 5x5 frame plus the 3x3 back-to-back-row frame
    run(40, -1, -1, -1, -1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      vec_t e;
      e = tbl[i];
      chk($sformatf("tbl_c%0d_rd_en", e.cyc), log_rd[e.cyc], e.rd);
      chk($sformatf("tbl_c%0d_valid", e.cyc), log_v[e.cyc], e.v);
      chk($sformatf("tbl_c%0d_row", e.cyc), log_row[e.cyc], e.row);
      chk($sformatf("tbl_c%0d_col", e.cyc), log_col[e.cyc], e.col);
      chk($sformatf("tbl_c%0d_busy", e.cyc), log_busy[e.cyc], e.busy);
      chk($sformatf("tbl_c%0d_done", e.cyc), log_done[e.cyc], e.done);
      if (e.rd != 0) chk($sformatf("tbl_c%0d_addr", e.cyc), log_addr[e.cyc], e.addr);
      if (e.v != 0) chk($sformatf("tbl_c%0d_data", e.cyc), log_d[e.cyc], e.d);
    end
    check_frame("base", 40, 99, 0);

    bad = 0; nv = 0; nd = 0; nr = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (logb_rd[c] != ((c >= 1 && c <= 9) ? 1 : 0)) bad++;
      if (logb_rd[c] != 0) begin
        if (logb_addr[c] != c - 1) bad++;
        nr++;
      end
      if (logb_v[c] != ((c >= 2 && c <= 10) ? 1 : 0)) bad++;
      if (logb_v[c] != 0) begin
        if (logb_d[c] != nv) bad++;
        nv++;
      end
      if (logb_done[c] != 0) begin nd++; done_at = c; end
    end
    chk("gap0_window_errs", bad, 0);
    chk("gap0_rd_count", nr, 9);
    chk("gap0_valid_count", nv, 9);
    chk("gap0_done_pulses", nd, 1);
    chk("gap0_done_cycle", done_at, 11);

    // back-pressure during row 0
    run(40, 3, 4, -1, -1, 1'b0);
    chk("hold_rd_c3", log_rd[3], 0);
    chk("hold_rd_c4", log_rd[4], 0);
    chk("hold_valid_c3", log_v[3], 1);
    chk("hold_data_c3", log_d[3], 1);
    chk("hold_valid_c4", log_v[4], 0);
    chk("hold_rd_c5_addr", log_addr[5], 2);
    check_frame("hold", 40, 2, 2);

    // start pulse while busy
    run(40, -1, -1, 10, -1, 1'b0);
    check_frame("busy_start", 40, 99, 0);

    // start held high: second frame starts right after IDLE is reached
    run(40, -1, -1, -1, -1, 1'b1);
    check_frame("start_held", 36, 99, 0);
    chk("start_held_busy_c36", log_busy[36], 0);
    chk("start_held_rd_c36", log_rd[36], 0);
    chk("start_held_rd_c37", log_rd[37], 1);
    chk("start_held_addr_c37", log_addr[37], 0);
    chk("start_held_busy_c37", log_busy[37], 1);
    do_reset();

    // reset mid-frame, then a clean frame
    run(16, -1, -1, -1, 14, 1'b0);
    chk("midrst_pre_busy_c14", log_busy[14], 1);
    chk("midrst_rd_c15", log_rd[15], 0);
    chk("midrst_addr_c15", log_addr[15], 0);
    chk("midrst_valid_c15", log_v[15], 0);
    chk("midrst_row_c15", log_row[15], 0);
    chk("midrst_col_c15", log_col[15], 0);
    chk("midrst_busy_c15", log_busy[15], 0);
    chk("midrst_done_c15", log_done[15], 0);
    run(40, -1, -1, -1, -1, 1'b0);
    check_frame("after_rst", 40, 99, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
